// File: rtl/status_pkg.sv
// Shared definitions for the status monitor slice.
// STATUS_W: width of a core status code.
// ST_*: status code values produced by core; ST_ILLEGAL is never legal.
// mon_state_e: monitor FSM states.
package status_pkg;

  localparam int STATUS_W = 3;

  localparam logic [STATUS_W-1:0] ST_R       = 3'd0;
  localparam logic [STATUS_W-1:0] ST_I       = 3'd1;
  localparam logic [STATUS_W-1:0] ST_S       = 3'd2;
  localparam logic [STATUS_W-1:0] ST_B       = 3'd3;
  localparam logic [STATUS_W-1:0] ST_U       = 3'd4;
  localparam logic [STATUS_W-1:0] ST_INVALID = 3'd5;
  localparam logic [STATUS_W-1:0] ST_EOF     = 3'd6;
  localparam logic [STATUS_W-1:0] ST_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    RUN,
    DONE,
    TIMEOUT
  } mon_state_e;

  function automatic logic is_terminal(input logic [STATUS_W-1:0] code);
    return (code == ST_INVALID) || (code == ST_EOF);
  endfunction

endpackage

// File: rtl/status_fifo.sv
// Small synchronous FIFO with registered storage and combinational head.
// clk/rst: clock, async active-high reset; clear: synchronous flush.
// push/wdata: write request; dropped when full unless a pop occurs too.
// pop: removes head when non-empty; ignored when empty.
// rdata: head entry; full/empty: occupancy flags.
module status_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/status_monitor.sv
// Consumes core's status stream: buffers codes in a FIFO, counts them per
// type and in total, detects terminal codes and flags protocol faults.
// i_clk/i_rst/i_clear: clock, async reset, sync clear (same effect as reset).
// i_status/i_status_valid: incoming status stream.
// o_rd_valid/o_rd_status/i_rd_ready: FIFO read side.
// o_type_cnt/o_total_cnt: saturating counters.
// o_done/o_term_code/o_timeout: completion state.
// o_extra/o_illegal/o_overflow: sticky fault flags.
module status_monitor
  import status_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 12,
  parameter int MAX_CYCLE = 120000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic [STATUS_W-1:0] i_status,
  input  logic                i_status_valid,
  output logic                o_rd_valid,
  output logic [STATUS_W-1:0] o_rd_status,
  input  logic                i_rd_ready,
  output logic [7*CNT_W-1:0]  o_type_cnt,
  output logic [CNT_W-1:0]    o_total_cnt,
  output logic                o_done,
  output logic [STATUS_W-1:0] o_term_code,
  output logic                o_timeout,
  output logic                o_extra,
  output logic                o_illegal,
  output logic                o_overflow
);

  localparam int CYC_W = $clog2(MAX_CYCLE) + 1;

  mon_state_e          state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]    cnt_q [7];
  logic [CNT_W-1:0]    cnt_d [7];
  logic [CNT_W-1:0]    total_q, total_d;
  logic [STATUS_W-1:0] term_code_q, term_code_d;
  logic                extra_q, extra_d;
  logic                illegal_q, illegal_d;
  logic                overflow_q, overflow_d;

  logic run, take, term, fifo_full, fifo_empty;

  assign run  = (state_q == RUN);
  // take: status is counted and offered to the FIFO (it may still be dropped).
  assign take = i_status_valid && run && (i_status != ST_ILLEGAL);
  assign term = take && is_terminal(i_status);

  status_fifo #(
    .WIDTH (STATUS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (i_clear),
    .push  (take),
    .wdata (i_status),
    .pop   (i_rd_ready),
    .rdata (o_rd_status),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    term_code_d = term_code_q;
    extra_d     = extra_q;
    illegal_d   = illegal_q;
    overflow_d  = overflow_q;
    if (i_clear) begin
      state_d     = RUN;
      cyc_d       = '0;
      for (int unsigned k = 0; k < 7; k++) cnt_d[k] = '0;
      total_d     = '0;
      term_code_d = '0;
      extra_d     = 1'b0;
      illegal_d   = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      if (i_status_valid && (i_status == ST_ILLEGAL)) illegal_d = 1'b1;
      if (i_status_valid && !run) extra_d = 1'b1;
      // Full FIFO is never empty, so a drop happens exactly when no pop is requested.
      if (take && fifo_full && !i_rd_ready) overflow_d = 1'b1;
      if (take) begin
        if (total_q != '1) total_d = total_q + CNT_W'(1);
        for (int unsigned k = 0; k < 7; k++) begin
          if ((i_status == STATUS_W'(k)) && (cnt_q[k] != '1)) cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
      if (run) begin
        cyc_d = cyc_q + CYC_W'(1);
        if (term) begin
          state_d     = DONE;
          term_code_d = i_status;
        end else if (cyc_q == CYC_W'(MAX_CYCLE - 1)) begin
          state_d = TIMEOUT;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= RUN;
      cyc_q       <= '0;
      for (int unsigned k = 0; k < 7; k++) cnt_q[k] <= '0;
      total_q     <= '0;
      term_code_q <= '0;
      extra_q     <= 1'b0;
      illegal_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      term_code_q <= term_code_d;
      extra_q     <= extra_d;
      illegal_q   <= illegal_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    o_type_cnt = '0;
    for (int unsigned k = 0; k < 7; k++) o_type_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  assign o_rd_valid  = !fifo_empty;
  assign o_total_cnt = total_q;
  assign o_done      = (state_q == DONE);
  assign o_term_code = term_code_q;
  assign o_timeout   = (state_q == TIMEOUT);
  assign o_extra     = extra_q;
  assign o_illegal   = illegal_q;
  assign o_overflow  = overflow_q;

endmodule
